// File: rtl/vga_timing_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA timing controller: default 640x480@60
// raster timing, derived totals, FSM state type, coordinate type and a small
// window-decode helper used for sync generation.
// -----------------------------------------------------------------------------
package vga_pkg;

  // Default horizontal timing (pixel clocks)
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;

  // Default vertical timing (lines)
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } vga_state_t;

  // Both totals must fit in 10 bits (<= 1024)
  typedef logic [9:0] coord_t;

  // True when lo <= v < hi
  function automatic logic in_window(coord_t v, coord_t lo, coord_t hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_timing_ctrl_if.sv
// -----------------------------------------------------------------------------
// vga_timing_ctrl_if
// Bundles the run request and raster outputs of the timing controller.
//   master : timing controller side (drives coordinates, strobes, sync/blank)
//   slave  : consumer side (pixel generators / mixer / DAC, drives enable)
// Signals: enable, x, y, frame_start, line_start, active, hsync_n, vsync_n,
//          blank_n.
// -----------------------------------------------------------------------------
interface vga_timing_ctrl_if;

  logic           enable;
  vga_pkg::coord_t x;
  vga_pkg::coord_t y;
  logic           frame_start;
  logic           line_start;
  logic           active;
  logic           hsync_n;
  logic           vsync_n;
  logic           blank_n;

  modport master (
    input  enable,
    output x, y, frame_start, line_start, active, hsync_n, vsync_n, blank_n
  );

  modport slave (
    output enable,
    input  x, y, frame_start, line_start, active, hsync_n, vsync_n, blank_n
  );

endinterface

// File: rtl/vga_timing_ctrl_sync_delay.sv
// -----------------------------------------------------------------------------
// sync_delay
// WIDTH x DEPTH register pipe with synchronous active-low reset to RST_VAL.
// DEPTH = 0 degenerates to a wire.
//   clk     : clock
//   reset_n : synchronous active-low reset (all stages load RST_VAL)
//   din     : pipe input
//   dout    : input delayed by DEPTH cycles
// -----------------------------------------------------------------------------
module sync_delay #(
  parameter int               WIDTH   = 3,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_pass
      // Clock and reset are intentionally unused in the pass-through build
      logic unused_ok;
      assign unused_ok = &{1'b0, clk, reset_n};
      assign dout      = din;
    end else begin : g_pipe
      logic [WIDTH-1:0] pipe_q [DEPTH];
      logic [WIDTH-1:0] pipe_d [DEPTH];

      // Next pipe contents: each stage takes its predecessor
      always_comb begin
        pipe_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
          pipe_d[i] = pipe_q[i-1];
        end
      end

      // Pipe registers, flushed to the inactive value on reset
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          for (int i = 0; i < DEPTH; i++) begin
            pipe_q[i] <= RST_VAL;
          end
        end else begin
          for (int i = 0; i < DEPTH; i++) begin
            pipe_q[i] <= pipe_d[i];
          end
        end
      end

      assign dout = pipe_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_ctrl.sv
// -----------------------------------------------------------------------------
// vga_timing_ctrl
// Raster sequencer for the pixel output path. Runs whole frames while enable
// is high (enable is only looked at in IDLE and on the last pixel of a frame),
// publishes fetch coordinates and start strobes, and delays the
// active/hsync/vsync decode by PIX_LAT cycles so it lines up with colour data.
//   clk     : pixel clock
//   reset_n : synchronous active-low reset
//   bus     : vga_timing_ctrl_if.master (enable in; x, y, frame_start,
//             line_start, active, hsync_n, vsync_n, blank_n out)
// -----------------------------------------------------------------------------
module vga_timing_ctrl
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int PIX_LAT  = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  vga_timing_ctrl_if.master  bus
);

  localparam int     H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int     V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam coord_t H_LAST  = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST  = coord_t'(V_TOTAL - 1);
  localparam coord_t H_ACT_C = coord_t'(H_ACTIVE);
  localparam coord_t V_ACT_C = coord_t'(V_ACTIVE);
  localparam coord_t HS_LO   = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t HS_HI   = coord_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam coord_t VS_LO   = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t VS_HI   = coord_t'(V_ACTIVE + V_FP + V_SYNC);

  vga_state_t state_q, state_d;
  coord_t     h_q, h_d;
  coord_t     v_q, v_d;
  logic       fs_q, fs_d;
  logic       ls_q, ls_d;
  logic [2:0] decode_s;   // {active, hsync_n, vsync_n} before the delay pipe
  logic [2:0] delayed_s;

  // Next-state, counter advance and start-strobe generation
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    fs_d    = 1'b0;
    ls_d    = 1'b0;
    case (state_q)
      IDLE: begin
        h_d = 10'd0;
        v_d = 10'd0;
        if (bus.enable) begin
          state_d = RUN;
          fs_d    = 1'b1;
          ls_d    = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (h_q == H_LAST) begin
          h_d = 10'd0;
          if (v_q == V_LAST) begin
            // Frame boundary: the only point where enable is honoured in RUN
            v_d = 10'd0;
            if (bus.enable) begin
              state_d = RUN;
              fs_d    = 1'b1;
              ls_d    = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            v_d  = v_q + 10'd1;
            ls_d = (v_d < V_ACT_C);
          end
        end else begin
          h_d = h_q + 10'd1;
        end
      end
      default: begin
        state_d = IDLE;
        h_d     = 10'd0;
        v_d     = 10'd0;
      end
    endcase
  end

  // State, counter and strobe registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      h_q     <= 10'd0;
      v_q     <= 10'd0;
      fs_q    <= 1'b0;
      ls_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
      fs_q    <= fs_d;
      ls_q    <= ls_d;
    end
  end

  // Raster decode; IDLE feeds the pipe the inactive pattern
  always_comb begin
    decode_s = 3'b011;
    if (state_q == RUN) begin
      decode_s[2] = (h_q < H_ACT_C) && (v_q < V_ACT_C);
      decode_s[1] = !in_window(h_q, HS_LO, HS_HI);
      decode_s[0] = !in_window(v_q, VS_LO, VS_HI);
    end else begin
      decode_s = 3'b011;
    end
  end

  sync_delay #(
    .WIDTH   (3),
    .DEPTH   (PIX_LAT),
    .RST_VAL (3'b011)
  ) u_sync_delay (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (decode_s),
    .dout    (delayed_s)
  );

  assign bus.x           = h_q;
  assign bus.y           = v_q;
  assign bus.frame_start = fs_q;
  assign bus.line_start  = ls_q;
  assign bus.active      = delayed_s[2];
  assign bus.hsync_n     = delayed_s[1];
  assign bus.vsync_n     = delayed_s[0];
  assign bus.blank_n     = delayed_s[2];

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_ctrl
// Directed bench for vga_timing_ctrl using a reduced raster (15x9, 8x4
// visible) so whole frames fit in a short run. One instance uses PIX_LAT=2,
// a second uses PIX_LAT=0.
// Reduced timing: H 8/2/3/2 -> hsync low for h in [10,13); V 4/1/2/2 ->
// vsync low for lines [5,7); frame = 135 cycles.
// -----------------------------------------------------------------------------
module tb_vga_timing_ctrl;

  localparam int HA = 8, HF = 2, HSY = 3, HB = 2;
  localparam int VA = 4, VF = 1, VSY = 2, VB = 2;
  localparam int HT = 15;
  localparam int FRAME = 135;
  localparam int NEVER = 1000000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  vga_timing_ctrl_if bus2();
  vga_timing_ctrl_if bus0();

  vga_timing_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .PIX_LAT(2)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .bus(bus2)
  );

  vga_timing_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .PIX_LAT(0)
  ) u_dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0)
  );

  always #5 clk = ~clk;

  // Undelayed {active, hsync_n, vsync_n} at frame-relative time t
  function automatic logic [2:0] pre_at(int t, int run_end);
    int p, h, v;
    if (t < 0 || t >= run_end) return 3'b011;
    p = t % FRAME;
    h = p % HT;
    v = p / HT;
    return {(h < HA) && (v < VA), !((h >= 10) && (h < 13)), !((v >= 5) && (v < 7))};
  endfunction

  // Expected {x, y, frame_start, line_start, active, hsync_n, vsync_n, blank_n}
  function automatic logic [25:0] exp_vec(int t, int run_end, int lat);
    logic [2:0] d;
    logic [9:0] ex, ey;
    logic       fs, ls;
    int         p;
    d  = pre_at(t - lat, run_end);
    ex = 10'd0; ey = 10'd0; fs = 1'b0; ls = 1'b0;
    if (t >= 0 && t < run_end) begin
      p  = t % FRAME;
      ex = 10'(p % HT);
      ey = 10'(p / HT);
      fs = (p == 0);
      ls = ((p % HT) == 0) && ((p / HT) < VA);
    end
    return {ex, ey, fs, ls, d[2], d[1], d[0], d[2]};
  endfunction

  function automatic logic [25:0] obs2();
    return {bus2.x, bus2.y, bus2.frame_start, bus2.line_start,
            bus2.active, bus2.hsync_n, bus2.vsync_n, bus2.blank_n};
  endfunction

  function automatic logic [25:0] obs0();
    return {bus0.x, bus0.y, bus0.frame_start, bus0.line_start,
            bus0.active, bus0.hsync_n, bus0.vsync_n, bus0.blank_n};
  endfunction

  task automatic test_reset();
    logic [25:0] rst_vec;
    rst_vec = {10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    reset_n = 1'b0;
    bus2.enable = 1'b1;
    bus0.enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs2() !== rst_vec) begin
        n_fail++;
        $display("FAIL reset_hold cycle %0d: got %h expected %h", i, obs2(), rst_vec);
      end
    end
    reset_n = 1'b1;
  endtask

  task automatic test_first_frame();
    logic [25:0] e;
    int act_cnt = 0, hs_cnt = 0, vs_cnt = 0;
    int hs_first = -1, vs_first = -1, ls2 = -1;
    for (int t = 0; t < FRAME; t++) begin
      @(negedge clk);
      e = exp_vec(t, NEVER, 2);
      n_checks++;
      if (obs2() !== e) begin
        n_fail++;
        $display("FAIL frame_scan t=%0d: got %h expected %h", t, obs2(), e);
      end
      if (bus2.active === 1'b1) act_cnt++;
      if (bus2.hsync_n === 1'b0) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = t;
      end
      if (bus2.vsync_n === 1'b0) begin
        vs_cnt++;
        if (vs_first < 0) vs_first = t;
      end
      if (bus2.line_start === 1'b1 && t > 0 && ls2 < 0) ls2 = t;
    end
    n_checks++;
    if (act_cnt !== 32) begin n_fail++; $display("FAIL active_count: got %0d expected 32", act_cnt); end
    n_checks++;
    if (hs_cnt !== 27) begin n_fail++; $display("FAIL hsync_low_count: got %0d expected 27", hs_cnt); end
    n_checks++;
    if (hs_first !== 12) begin n_fail++; $display("FAIL hsync_first_low: got %0d expected 12", hs_first); end
    n_checks++;
    if (vs_cnt !== 30) begin n_fail++; $display("FAIL vsync_low_count: got %0d expected 30", vs_cnt); end
    n_checks++;
    if (vs_first !== 77) begin n_fail++; $display("FAIL vsync_first_low: got %0d expected 77", vs_first); end
    n_checks++;
    if (ls2 !== 15) begin n_fail++; $display("FAIL second_line_start: got %0d expected 15", ls2); end
  endtask

  task automatic test_back_to_back();
    logic [25:0] e;
    for (int t = FRAME; t < 165; t++) begin
      @(negedge clk);
      e = exp_vec(t, NEVER, 2);
      n_checks++;
      if (obs2() !== e) begin
        n_fail++;
        $display("FAIL b2b_scan t=%0d: got %h expected %h", t, obs2(), e);
      end
      if (t == FRAME) begin
        n_checks++;
        if (bus2.frame_start !== 1'b1 || bus2.x !== 10'd0 || bus2.y !== 10'd0) begin
          n_fail++;
          $display("FAIL b2b_frame_start: got fs=%b x=%0d y=%0d expected fs=1 x=0 y=0",
                   bus2.frame_start, bus2.x, bus2.y);
        end
      end
    end
    // Drop enable mid-frame: the frame must still run to (14,8)
    bus2.enable = 1'b0;
  endtask

  task automatic test_stop_restart();
    logic [25:0] e;
    for (int t = 165; t < 290; t++) begin
      @(negedge clk);
      e = exp_vec(t, 2 * FRAME, 2);
      n_checks++;
      if (obs2() !== e) begin
        n_fail++;
        $display("FAIL stop_scan t=%0d: got %h expected %h", t, obs2(), e);
      end
    end
    bus2.enable = 1'b1;
    for (int t = 0; t < 35; t++) begin
      @(negedge clk);
      e = exp_vec(t, NEVER, 2);
      n_checks++;
      if (obs2() !== e) begin
        n_fail++;
        $display("FAIL restart_scan t=%0d: got %h expected %h", t, obs2(), e);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [25:0] e;
    logic [25:0] rst_vec;
    rst_vec = {10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    // Counters now at (4,2) with active pixels in flight
    reset_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (obs2() !== rst_vec) begin
      n_fail++;
      $display("FAIL reset_mid_frame: got %h expected %h", obs2(), rst_vec);
    end
    reset_n = 1'b1;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      e = exp_vec(t, NEVER, 2);
      n_checks++;
      if (obs2() !== e) begin
        n_fail++;
        $display("FAIL post_reset_scan t=%0d: got %h expected %h", t, obs2(), e);
      end
    end
  endtask

  task automatic test_pix_lat0();
    logic [25:0] e;
    n_checks++;
    if (bus0.active !== 1'b0 || bus0.x !== 10'd0 || bus0.frame_start !== 1'b0) begin
      n_fail++;
      $display("FAIL lat0_idle: got active=%b x=%0d fs=%b expected 0 0 0",
               bus0.active, bus0.x, bus0.frame_start);
    end
    bus0.enable = 1'b1;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      e = exp_vec(t, NEVER, 0);
      n_checks++;
      if (obs0() !== e) begin
        n_fail++;
        $display("FAIL lat0_scan t=%0d: got %h expected %h", t, obs0(), e);
      end
      if (t == 0) begin
        n_checks++;
        if (bus0.active !== 1'b1 || bus0.frame_start !== 1'b1) begin
          n_fail++;
          $display("FAIL lat0_same_cycle: got active=%b fs=%b expected 1 1",
                   bus0.active, bus0.frame_start);
        end
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus2.enable = 1'b0;
    bus0.enable = 1'b0;
    test_reset();
    test_first_frame();
    test_back_to_back();
    test_stop_restart();
    test_reset_mid_frame();
    test_pix_lat0();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_ctrl.md
# vga_timing_ctrl

Sequencer for the pixel output path: generates the raster scan (800×525 at 25 MHz for 640×480@60), issues pixel fetch coordinates to the background/sprite generators, and drives the `active` qualifier consumed by the output mixer. Sync and blank signals are delayed by a configurable fetch latency so they stay aligned with the colour data reaching the mixer and the VGA DAC.

## Interface
Parameters:
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (cycles)
- `H_SYNC`, 96, horizontal sync width
- `H_BP`, 48, horizontal back porch
- `V_ACTIVE`, 480, visible lines
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width
- `V_BP`, 33, vertical back porch
- `PIX_LAT`, 2, cycles from `x`/`y` to colour valid at mixer input; 0..7

Ports:
- `clk` in 1: pixel clock
- `reset_n` in 1: reset, synchronous, active-low
- `enable` in 1: run request, sampled only at frame boundaries
- `x` out 10: horizontal fetch coordinate (raw hcount)
- `y` out 10: vertical fetch coordinate (raw vcount)
- `frame_start` out 1: one-cycle pulse at (x,y)=(0,0)
- `line_start` out 1: one-cycle pulse at x=0 on visible lines
- `active` out 1: visible-pixel qualifier for the mixer, aligned to colour data
- `hsync_n` out 1: horizontal sync, active-low, aligned to `active`
- `vsync_n` out 1: vertical sync, active-low, aligned to `active`
- `blank_n` out 1: DAC blank, equals `active`

## Operation
- H_TOTAL = sum of horizontal params (800); V_TOTAL = sum of vertical params (525). Both must be ≤ 1024.
- FSM `IDLE`, `RUN`:
  - `IDLE`: counters held at 0; `frame_start` and `line_start` are 0; the delay pipe is fed inactive values (active=0, hsync_n=1, vsync_n=1). If `enable`=1, go to `RUN`.
  - `RUN`: hcount increments each cycle and wraps at H_TOTAL-1 while vcount increments. At (H_TOTAL-1, V_TOTAL-1): if `enable`=1, wrap to (0,0) and stay in `RUN`; else go to `IDLE`.
- Deasserting `enable` mid-frame has no effect until the frame completes. Frames are never truncated.
- `x`, `y`, `frame_start` and `line_start` are registered and reflect the current counters.
- Undelayed decode from the counters:
  - active_pre = hcount < H_ACTIVE and vcount < V_ACTIVE
  - hs_pre low for hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC)
  - vs_pre low for vcount in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), for full lines
- `active`, `hsync_n`, `vsync_n` and `blank_n` are the decode passed through a PIX_LAT-stage register pipe. With PIX_LAT=0 they are combinational from the counter registers.
- Reset (`reset_n`=0 at an edge): state `IDLE`, counters 0, pipe flushed to inactive. Outputs next cycle: x=0, y=0, frame_start=0, line_start=0, active=0, blank_n=0, hsync_n=1, vsync_n=1. A reset mid-frame takes effect immediately, and the next run starts a fresh frame.

## Timing
- The cycle after `enable` is sampled high in `IDLE`: x=0, y=0, frame_start=1, line_start=1.
- `active` for pixel (X,Y) is asserted exactly PIX_LAT cycles after `x`=X, `y`=Y is presented.
- Frame period: H_TOTAL×V_TOTAL cycles (420000). Line period: H_TOTAL cycles.
- hsync_n low for H_SYNC consecutive cycles per line. vsync_n low for V_SYNC×H_TOTAL consecutive cycles, starting at hcount=0 of line V_ACTIVE+V_FP (plus PIX_LAT).
- Back-to-back frames have no gap cycle. Counter (H_TOTAL-1, V_TOTAL-1) is followed directly by (0,0) with frame_start=1.
- Re-entry after stop: at least one `IDLE` cycle between the last pixel of the previous frame and the next frame_start.

## Structure
- Package `vga_pkg`:
  - default timing constants (H_*/V_*)
  - derived H_TOTAL, V_TOTAL
  - `vga_state_t` enum {IDLE, RUN}
  - coordinate typedef `coord_t` (logic [9:0])
- One sub-module, `sync_delay`: a parameterised WIDTH×DEPTH register pipe with synchronous active-low reset to a parameterised reset value. It is instantiated once with WIDTH=3 for {active, hsync_n, vsync_n}, reset value 3'b011. DEPTH=0 is a pass-through.

## Test plan
- Reset hold 5 cycles with enable=1 → outputs x=0, y=0, active=0, blank_n=0, hsync_n=1, vsync_n=1; no frame_start while reset_n=0.
- Release reset, enable=1, PIX_LAT=2 → frame_start at (0,0); active rises 2 cycles later, is high 640 cycles, then low 160 cycles; second line_start 800 cycles after the first.
- Run one full frame → hsync_n low 96 cycles beginning 656+2 cycles after line_start; vsync_n low 1600 cycles starting at line 490; next frame_start exactly 420000 cycles after the first.
- Drop enable at line 100 → frame completes to (799,524); FSM enters `IDLE`; x/y stay 0; no further frame_start until enable returns; the next frame starts cleanly.
- Assert reset_n=0 for 1 cycle at (300,200) → next cycle all outputs at reset values; pipe flushed, with no stale active pulse after reset.
- PIX_LAT=0 build → active high in the same cycle as x=0, y=0; active_pre and active are identical.
